// File: rtl/range_slice_arbiter.sv
// range_slice_arbiter
//   Round-robin arbiter in front of one shared bit-range extraction datapath.
//   The granted requester's word and [msb:lsb] are latched and the range is
//   validated. The word is then shifted right one bit per cycle, lsb times,
//   and masked to msb-lsb+1 bits. The right-justified slice comes back with a
//   one-cycle ack to that requester.
//
//   Optional build macro: RANGE_SWAP_EN
//     When defined, msb<lsb is accepted and the two indices are swapped.
//     When undefined, msb<lsb is reported as a range error.
//
// Ports
//   clk       clock, posedge
//   rst       synchronous reset, active low
//   req       per-requester request level, held until ack
//   req_data  requester i word at [i*DW +: DW]
//   req_msb   requester i msb at [i*IDXW +: IDXW]
//   req_lsb   requester i lsb at [i*IDXW +: IDXW]
//   ack       one-hot one-cycle pulse, coincident with rvalid
//   busy      high while a transaction occupies CHECK..DONE
//   rvalid    one-cycle result strobe
//   rdata     right-justified slice, held until the next result
//   rerr      range error flag, valid with rvalid, held like rdata
//   rid       index of the requester being served, held until next grant
module range_slice_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int IDXW = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  input  logic [NREQ*IDXW-1:0]    req_msb,
  input  logic [NREQ*IDXW-1:0]    req_lsb,
  output logic [NREQ-1:0]         ack,
  output logic                    busy,
  output logic                    rvalid,
  output logic [DW-1:0]           rdata,
  output logic                    rerr,
  output logic [$clog2(NREQ)-1:0] rid
);
  localparam int RIDW = $clog2(NREQ);
  localparam logic [IDXW:0]   DWV  = (IDXW+1)'(DW);
  localparam logic [IDXW:0]   DWM1 = (IDXW+1)'(DW-1);
  localparam logic [DW-1:0]   ONES = '1;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [IDXW-1:0] msb;
    logic [IDXW-1:0] lsb;
  } rq_t;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SHIFT, S_MASK, S_DONE} state_t;

  rq_t [NREQ-1:0] rq;

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_unpack
      assign rq[g].data = req_data[g*DW +: DW];
      assign rq[g].msb  = req_msb[g*IDXW +: IDXW];
      assign rq[g].lsb  = req_lsb[g*IDXW +: IDXW];
    end
  endgenerate

  state_t          state_q, state_d;
  logic [RIDW-1:0] ptr;
  logic [DW-1:0]   work;
  logic [IDXW-1:0] msb_q, lsb_q, cnt;
  logic            err_q;

  // Arbitration: first eligible requester at or after ptr, wrapping.
  // The requester being acked this cycle is still holding req, so it is
  // masked out here; it only competes again if req is still high next cycle.
  logic [NREQ-1:0] elig;
  logic            gnt_any;
  logic [RIDW-1:0] gnt_idx, cand;
  int              j;

  assign elig = req & ~ack;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    j       = 0;
    // descending scan so the closest candidate to ptr is written last
    for (int k = NREQ-1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      cand = RIDW'(j);
      if (elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Range checks on the latched indices (valid in CHECK)
  logic            msb_bad, lsb_bad, inv, swap, bad;
  logic [IDXW-1:0] lo;
  logic [IDXW:0]   span, msh;
  logic [DW-1:0]   mask;

  always_comb begin
    msb_bad = {1'b0, msb_q} >= DWV;
    lsb_bad = {1'b0, lsb_q} >= DWV;
    inv     = msb_q < lsb_q;
`ifdef RANGE_SWAP_EN
    swap    = inv;
    bad     = msb_bad | lsb_bad;
`else
    swap    = 1'b0;
    bad     = msb_bad | lsb_bad | inv;
`endif
    lo      = swap ? msb_q : lsb_q;
    // width-1 = msb-lsb, so shifting all-ones right by DW-1-(msb-lsb)
    // yields exactly width ones; full width is a shift of zero
    span    = {1'b0, msb_q} - {1'b0, lsb_q};
    msh     = DWM1 - span;
    mask    = ONES >> msh;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_any) state_d = S_CHECK;
      S_CHECK: begin
        if (bad)           state_d = S_DONE;
        else if (lo == '0) state_d = S_MASK;
        else               state_d = S_SHIFT;
      end
      S_SHIFT: if (cnt == IDXW'(1)) state_d = S_MASK;
      S_MASK:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr     <= '0;
      work    <= '0;
      msb_q   <= '0;
      lsb_q   <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      ack     <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rerr    <= 1'b0;
      rid     <= '0;
    end else begin
      state_q <= state_d;
      ack     <= '0;
      rvalid  <= 1'b0;
      case (state_q)
        S_IDLE: if (gnt_any) begin
          work  <= rq[gnt_idx].data;
          msb_q <= rq[gnt_idx].msb;
          lsb_q <= rq[gnt_idx].lsb;
          err_q <= 1'b0;
          rid   <= gnt_idx;
          ptr   <= (gnt_idx == RIDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
        S_CHECK: begin
          if (bad) begin
            err_q <= 1'b1;
            work  <= '0;
          end else begin
            cnt <= lo;
            if (swap) begin
              msb_q <= lsb_q;
              lsb_q <= msb_q;
            end
          end
        end
        S_SHIFT: begin
          work <= work >> 1;
          cnt  <= cnt - 1'b1;
        end
        S_MASK: work <= work & mask;
        S_DONE: begin
          rvalid <= 1'b1;
          ack    <= NREQ'(1) << rid;
          rdata  <= work;
          rerr   <= err_q;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_range_slice_arbiter.sv
// Randomized + directed bench for range_slice_arbiter.
// Expected results come from an arithmetic slice model and a round-robin
// pointer model kept in the bench.
module tb_range_slice_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int IDXW = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ*IDXW-1:0] req_msb = '0;
  logic [NREQ*IDXW-1:0] req_lsb = '0;
  logic [NREQ-1:0]      ack;
  logic                 busy, rvalid, rerr;
  logic [DW-1:0]        rdata;
  logic [1:0]           rid;

  range_slice_arbiter #(.NREQ(NREQ), .DW(DW), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .req_msb(req_msb), .req_lsb(req_lsb), .ack(ack), .busy(busy),
    .rvalid(rvalid), .rdata(rdata), .rerr(rerr), .rid(rid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rr_m   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // slice model: plain arithmetic on the spec's rules
  function automatic void model(input logic [31:0] d, input int m, input int l,
                                output logic e, output logic [31:0] r, output int lat);
    int hi, lo;
    logic [63:0] full, msk;
    e = 1'b0; r = '0; hi = m; lo = l;
    if (m >= DW || l >= DW) e = 1'b1;
    else if (m < l) begin
`ifdef RANGE_SWAP_EN
      hi = l; lo = m;
`else
      e = 1'b1;
`endif
    end
    if (e) lat = 2;
    else begin
      full = {32'b0, d} >> lo;
      msk  = (64'd1 << (hi - lo + 1)) - 64'd1;
      r    = 32'(full & msk);
      lat  = 3 + lo;
    end
  endfunction

  function automatic int winner(input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++)
      if (m[(rr_m + k) % NREQ]) return (rr_m + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] d, input int m, input int l);
    req_data[i*DW +: DW]     = d;
    req_msb[i*IDXW +: IDXW]  = IDXW'(m);
    req_lsb[i*IDXW +: IDXW]  = IDXW'(l);
  endtask

  // raise mask m while idle, expect the model's winner with model latency
  task automatic serve(input logic [NREQ-1:0] m);
    int w, n, lat;
    logic e;
    logic [31:0] r;
    w = winner(m);
    model(req_data[w*DW +: DW], int'(req_msb[w*IDXW +: IDXW]),
          int'(req_lsb[w*IDXW +: IDXW]), e, r, lat);
    req = m;
    tick();
    n = 1;
    chk("busy", busy, 1);
    while (ack == '0 && n < 60) begin tick(); n++; end
    chk("latency", n, lat + 1);
    chk("ack", ack, 64'd1 << w);
    chk("rvalid", rvalid, 1);
    chk("rid", rid, w);
    chk("rdata", rdata, r);
    chk("rerr", rerr, e);
    chk("busy_idle", busy, 0);
    req = '0;
    rr_m = (w + 1) % NREQ;
    tick();
    chk("rdata_hold", rdata, r);
    chk("rvalid_pulse", rvalid, 0);
  endtask

  initial begin
    int n, w, mm, ll;
    logic [NREQ-1:0] acc, m;
    logic e;
    logic [31:0] r;
    int lat;

    // reset state
    tick(); tick();
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", rid, 0);
    rst = 1'b1;
    tick();

    // directed
    set_req(0, 32'h000000A5, 7, 4);
    serve(4'b0001);
    chk("a5_slice", rdata, 32'hA);
    set_req(1, 32'hDEADBEEF, 31, 0);
    serve(4'b0010);
    chk("full_width", rdata, 32'hDEADBEEF);
    set_req(2, $urandom, 40, 0);
    serve(4'b0100);
    chk("oor_err", rerr, 1);
    set_req(2, 32'h3C, 2, 5);
    serve(4'b0100);
    set_req(2, 32'hFFFF_FFFF, 31, 0);
    serve(4'b0100);

    // reset while shifting for req2
    set_req(2, 32'h1234_5678, 20, 12);
    req = 4'b0100;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_rerr", rerr, 0);
    chk("mid_rst_rid", rid, 0);
    rst = 1'b1;
    req = '0;
    rr_m = 0;
    acc = '0;
    for (int i = 0; i < 20; i++) begin tick(); acc |= ack; end
    chk("no_ack_after_rst", acc, 0);
    set_req(0, 32'hCAFE_F00D, 15, 8);
    set_req(2, 32'h0BAD_0BAD, 11, 1);
    serve(4'b0101);

    // req0 dropped right after grant
    set_req(0, 32'h89AB_CDEF, 23, 9);
    model(32'h89AB_CDEF, 23, 9, e, r, lat);
    req = 4'b0001;
    tick();
    req = '0;
    n = 1;
    while (ack == '0 && n < 60) begin tick(); n++; end
    chk("drop_latency", n, lat + 1);
    chk("drop_ack", ack, 1);
    chk("drop_rdata", rdata, r);
    acc = '0;
    for (int i = 0; i < 15; i++) begin tick(); acc |= ack; acc[0] |= busy; end
    chk("no_regrant", acc, 0);
    rr_m = 1;

    // all four held, each drops one cycle after its ack: 0,1,2,3,0
    rst = 1'b0; tick(); rst = 1'b1; rr_m = 0;
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom_range(0, 31), 0);
    req = '1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin tick(); n++; end while (ack == '0 && n < 60);
      w = rr_m;
      model(req_data[w*DW +: DW], int'(req_msb[w*IDXW +: IDXW]), 0, e, r, lat);
      chk("rr_order", ack, 64'd1 << w);
      chk("rr_rdata", rdata, r);
      rr_m = (w + 1) % NREQ;
      if (k == 4) begin
        req = '0;
        tick();
      end else begin
        req[w] = 1'b0;
        tick();
        req[w] = 1'b1;
      end
    end
    serve(4'b0010);
    serve(4'b1000);
    serve(4'b0001);

    // randomized subsets and ranges
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        mm = $urandom_range(0, 31);
        ll = $urandom_range(0, 31);
        case ($urandom_range(0, 9))
          0: mm = $urandom_range(32, 63);
          1: ll = $urandom_range(32, 63);
          2, 3: ;
          default: if (mm < ll) begin n = mm; mm = ll; ll = n; end
        endcase
        set_req(i, $urandom, mm, ll);
      end
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      serve(m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
